// File: rtl/button_reader.sv
// button_reader: reads one active-low pushbutton on the 100 MHz clock.
// The raw pin is synchronised with two flops and then debounced. The block
// reports a clean held level and one-cycle press, release and long-press
// pulses, and keeps a wrapping count of accepted presses.
module button_reader #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int CNT_W           = 8
) (
    input  logic             CLOCK_100Mhz,
    input  logic             reset,
    input  logic             KEY_n,
    output logic             pressed,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    // The raw sample that moves the FSM out of IDLE or HELD is already the
    // first stable sample, so the debounce timer starts at 1. Acceptance then
    // happens on the DEBOUNCE_CYCLES-th consecutive stable sample of raw,
    // which is DEBOUNCE_CYCLES edges after raw first shows the new level.
    localparam logic [DB_W-1:0]   DB_FIRST  = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } state_t;

    state_t              state;
    logic                s1;
    logic                s2;
    logic                raw;
    logic [DB_W-1:0]     db_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                long_done;
    logic                hold_active;
    logic                long_hit;

    // Two-flop synchroniser; both stages rest at the released level.
    always_ff @(posedge CLOCK_100Mhz) begin
        if (!reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= KEY_n;
            s2 <= s1;
        end
    end

    // Active-high view of the synchronised button.
    assign raw = ~s2;

    // The hold timer runs whenever the button is accepted as held, which
    // includes the release-debounce window, so a long press can still land
    // while a release is being debounced.
    always_comb begin
        hold_active = (state == HELD) || (state == DB_RELEASE);
        long_hit    = hold_active && (hold_cnt == HOLD_LAST) && !long_done;
    end

    // Debounce FSM with the hold timer and all registered outputs.
    always_ff @(posedge CLOCK_100Mhz) begin
        if (!reset) begin
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= '0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;

            if (hold_active) begin
                if (hold_cnt < HOLD_MAX) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
                if (long_hit) begin
                    long_pulse <= 1'b1;
                    long_done  <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (raw) begin
                        state  <= DB_PRESS;
                        db_cnt <= DB_FIRST;
                    end
                end
                DB_PRESS: begin
                    if (!raw) begin
                        state <= IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= HELD;
                        pressed     <= 1'b1;
                        press_pulse <= 1'b1;
                        press_count <= press_count + CNT_W'(1);
                        hold_cnt    <= '0;
                        long_done   <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!raw) begin
                        state  <= DB_RELEASE;
                        db_cnt <= DB_FIRST;
                    end
                end
                DB_RELEASE: begin
                    if (raw) begin
                        // Bounce: back to held, hold timer keeps running.
                        state <= HELD;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= IDLE;
                        pressed       <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// CNT_W=3. Latencies below are counted in clock edges from the edge at which
// a new KEY_n (or reset) level is first sampled: a clean change is accepted
// on the 6th edge counted that way (two synchroniser edges, then four
// consecutive stable samples).
module tb_button_reader;

    localparam int DB   = 4;
    localparam int LG   = 20;
    localparam int CW   = 3;

    logic          CLOCK_100Mhz;
    logic          reset;
    logic          KEY_n;
    logic          pressed;
    logic          press_pulse;
    logic          release_pulse;
    logic          long_pulse;
    logic [CW-1:0] press_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n_press, n_rel, n_long;
    int t_press, t_rel, t_long;
    int c0;

    button_reader #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG),
        .CNT_W          (CW)
    ) dut (
        .CLOCK_100Mhz (CLOCK_100Mhz),
        .reset        (reset),
        .KEY_n        (KEY_n),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    initial CLOCK_100Mhz = 1'b0;
    always #5 CLOCK_100Mhz = ~CLOCK_100Mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; sample 1 ns later and tally pulses with their edge index.
    task automatic step();
        @(posedge CLOCK_100Mhz);
        #1;
        cyc++;
        if (press_pulse   === 1'b1) begin n_press++; t_press = cyc; end
        if (release_pulse === 1'b1) begin n_rel++;   t_rel   = cyc; end
        if (long_pulse    === 1'b1) begin n_long++;  t_long  = cyc; end
    endtask

    task automatic clr();
        n_press = 0; n_rel = 0; n_long = 0;
        t_press = -1; t_rel = -1; t_long = -1;
    endtask

    task automatic do_reset();
        KEY_n = 1'b1;
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();
        clr();
    endtask

    initial begin
        clr();
        // Reset held with the button pressed: everything stays at zero.
        KEY_n = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            step();
            chk("rst_outputs", {25'd0, pressed, press_pulse, release_pulse, long_pulse, press_count}, 32'd0);
        end
        clr();
        reset = 1'b1;
        c0 = cyc;
        repeat (8) step();
        chk("rst_press_n",   n_press, 1);
        chk("rst_press_lat", t_press - c0, 6);
        chk("rst_count",     press_count, 1);
        chk("rst_pressed",   pressed, 1);
        chk("rst_no_rel",    n_rel, 0);

        // Clean press held 10 cycles, then clean release.
        do_reset();
        KEY_n = 1'b0;
        c0 = cyc;
        repeat (10) step();
        chk("clean_press_n",   n_press, 1);
        chk("clean_press_lat", t_press - c0, 6);
        chk("clean_pressed",   pressed, 1);
        chk("clean_count",     press_count, 1);
        KEY_n = 1'b1;
        c0 = cyc;
        repeat (10) step();
        chk("clean_rel_n",     n_rel, 1);
        chk("clean_rel_lat",   t_rel - c0, 6);
        chk("clean_released",  pressed, 0);
        chk("clean_no_long",   n_long, 0);
        chk("clean_press_n2",  n_press, 1);

        // Press bounce: 3 low, 1 high, 3 low, then high -> never accepted.
        do_reset();
        KEY_n = 1'b0; repeat (3) step();
        KEY_n = 1'b1; step();
        KEY_n = 1'b0; repeat (3) step();
        KEY_n = 1'b1; repeat (12) step();
        chk("bnc_press_n",  n_press, 0);
        chk("bnc_pressed",  pressed, 0);
        chk("bnc_count",    press_count, 0);

        // Release bounce while held: 3 high, 1 low, 3 high, then low again.
        KEY_n = 1'b0;
        repeat (8) step();
        chk("bncr_setup", pressed, 1);
        KEY_n = 1'b1; repeat (3) step();
        KEY_n = 1'b0; step();
        KEY_n = 1'b1; repeat (3) step();
        KEY_n = 1'b0; repeat (6) step();
        chk("bncr_pressed", pressed, 1);
        chk("bncr_rel_n",   n_rel, 0);

        // Long press: held 40 cycles.
        do_reset();
        KEY_n = 1'b0;
        c0 = cyc;
        repeat (40) step();
        chk("long_press_lat", t_press - c0, 6);
        chk("long_n",         n_long, 1);
        chk("long_lat",       t_long - t_press, 20);
        KEY_n = 1'b1;
        c0 = cyc;
        repeat (10) step();
        chk("long_rel_n",   n_rel, 1);
        chk("long_rel_lat", t_rel - c0, 6);
        chk("long_n_after", n_long, 1);
        chk("long_count",   press_count, 1);

        // Nine clean presses: count goes 1..7, 0, 1.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            KEY_n = 1'b0; repeat (8) step();
            chk("wrap_count", press_count, (i + 1) % 8);
            KEY_n = 1'b1; repeat (8) step();
        end
        chk("wrap_press_n", n_press, 9);
        chk("wrap_rel_n",   n_rel, 9);
        chk("wrap_no_long", n_long, 0);

        // Reset for one cycle at hold_cnt=10 with the button still down.
        do_reset();
        KEY_n = 1'b0;
        repeat (6) step();
        chk("mid_press_n", n_press, 1);
        repeat (10) step();
        reset = 1'b0;
        step();
        chk("mid_rst_pressed", pressed, 0);
        chk("mid_rst_count",   press_count, 0);
        chk("mid_rst_no_rel",  n_rel, 0);
        reset = 1'b1;
        c0 = cyc;
        n_press = 0;
        repeat (8) step();
        chk("mid_repress_n",   n_press, 1);
        chk("mid_repress_lat", t_press - c0, 6);
        chk("mid_count",       press_count, 1);
        chk("mid_no_rel",      n_rel, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
